// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU issue stage: opcode encoding, the bit positions
// inside the 2-bit overflow field, and the issue FSM state type.
// Optional feature macro: ALU_MUL_EN (used by alu_issue_stage). When it is
// defined, the shift-add multiplier is built.
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_ILL = 3'b111
  } alu_op_e;

  // Bit positions inside out_overflow.
  localparam int OVF_UNSIGNED = 0;  // carry, borrow, or high product half nonzero
  localparam int OVF_SIGNED   = 1;  // two's-complement overflow

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// In-order command queue holding {a, b, opcode} for the ALU issue stage.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH (name kept for compatibility)
//   i_push     write request; ignored while o_full
//   i_a, i_b   operands to enqueue
//   i_op       opcode to enqueue
//   i_pop      read request; ignored while o_empty
//   o_head_a/o_head_b/o_head_op  oldest entry (valid while !o_empty)
//   o_empty    no entries
//   o_full     DEPTH entries; there is no bypass, so a push is refused
// ---------------------------------------------------------------------------
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_a,
  output logic [WIDTH-1:0] o_head_b,
  output alu_op_e          o_head_op,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  alu_op_e          r_mem_op [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage is not reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= i_a;
      r_mem_b[r_wr_ptr]  <= i_b;
      r_mem_op[r_wr_ptr] <= i_op;
    end
  end

  assign o_head_a  = r_mem_a[r_rd_ptr];
  assign o_head_b  = r_mem_b[r_rd_ptr];
  assign o_head_op = r_mem_op[r_rd_ptr];

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Queues ALU commands in a FIFO, issues them in order, and holds each
// result in a single output register until it is consumed.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising
// edge where valid && ready. A producer must keep valid and its payload
// steady until the transfer. out_result/out_overflow/out_err are held
// stable while out_valid && !out_ready. in_ready does not depend on in_valid.
//
// Optional feature macro: ALU_MUL_EN. When defined, opcode MUL runs a
// WIDTH-cycle shift-add multiplier in state ST_MUL. When undefined, MUL is
// reported as an illegal opcode and no multiplier hardware exists.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active HIGH despite the name
//   in_valid     command offered
//   in_ready     FIFO not full
//   in_a, in_b   operands
//   in_opcode    3-bit opcode (see alu_pkg::alu_op_e)
//   out_valid    result register occupied
//   out_ready    consumer takes the result
//   out_result   result (modulo 2^WIDTH)
//   out_overflow bit0 unsigned carry/borrow/high-half, bit1 signed overflow
//   out_err      illegal or compiled-out opcode
//   o_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_overflow,
  output logic             out_err,
  output alu_state_e       o_dbg_state
);

  // ---------------- command FIFO ----------------
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  alu_op_e          w_head_op;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_pop;

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (in_valid),
    .i_a       (in_a),
    .i_b       (in_b),
    .i_op      (alu_op_e'(in_opcode)),
    .i_pop     (w_pop),
    .o_head_a  (w_head_a),
    .o_head_b  (w_head_b),
    .o_head_op (w_head_op),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  assign in_ready = !w_fifo_full;

  // ---------------- state and output registers ----------------
  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [1:0]       r_out_overflow;
  logic             r_out_err;

  logic             w_out_free;
  logic             w_load_out;
  logic [WIDTH-1:0] w_out_result_d;
  logic [1:0]       w_out_ovf_d;
  logic             w_out_err_d;
  logic             w_mul_start;
  logic             w_mul_issue;

  // The output slot can take a new value if empty or being drained this edge.
  assign w_out_free = !r_out_valid || out_ready;

  // ---------------- single-cycle ALU on the FIFO head ----------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_result;
  logic [1:0]       w_alu_ovf;
  logic             w_alu_err;
  logic             w_sign_a;
  logic             w_sign_b;

  assign w_sum    = {1'b0, w_head_a} + {1'b0, w_head_b};
  // The extra top bit of the difference is the unsigned borrow (a < b).
  assign w_diff   = {1'b0, w_head_a} - {1'b0, w_head_b};
  assign w_sign_a = w_head_a[WIDTH-1];
  assign w_sign_b = w_head_b[WIDTH-1];

  always_comb begin
    w_alu_result = '0;
    w_alu_ovf    = '0;
    w_alu_err    = 1'b0;
    case (w_head_op)
      OP_ADD: begin
        w_alu_result            = w_sum[WIDTH-1:0];
        w_alu_ovf[OVF_UNSIGNED] = w_sum[WIDTH];
        w_alu_ovf[OVF_SIGNED]   = (w_sign_a == w_sign_b) && (w_sum[WIDTH-1] != w_sign_a);
      end
      OP_SUB: begin
        w_alu_result            = w_diff[WIDTH-1:0];
        w_alu_ovf[OVF_UNSIGNED] = w_diff[WIDTH];
        w_alu_ovf[OVF_SIGNED]   = (w_sign_a != w_sign_b) && (w_diff[WIDTH-1] != w_sign_a);
      end
      OP_AND: w_alu_result = w_head_a & w_head_b;
      OP_OR:  w_alu_result = w_head_a | w_head_b;
      OP_XOR: w_alu_result = w_head_a ^ w_head_b;
      OP_NOT: w_alu_result = ~w_head_a;
      // OP_ILL, and OP_MUL when it never reaches the multiplier path.
      default: w_alu_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  // ---------------- shift-add multiplier ----------------
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mul_acc;
  logic [2*WIDTH-1:0] r_mul_mcand;
  logic [WIDTH-1:0]   r_mul_mplier;
  logic [CNT_W-1:0]   r_mul_cnt;
  logic [2*WIDTH-1:0] w_mul_acc_step;
  logic               w_mul_last;

  assign w_mul_issue    = (w_head_op == OP_MUL);
  assign w_mul_acc_step = r_mul_mplier[0] ? (r_mul_acc + r_mul_mcand) : r_mul_acc;
  assign w_mul_last     = (r_mul_cnt == MUL_LAST);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mul_acc    <= '0;
      r_mul_mcand  <= {{WIDTH{1'b0}}, w_head_a};
      r_mul_mplier <= w_head_b;
      r_mul_cnt    <= '0;
    end else if (r_state == ST_MUL) begin
      // One multiplier bit per cycle; after WIDTH steps r_mul_acc holds a*b.
      r_mul_acc    <= w_mul_acc_step;
      r_mul_mcand  <= r_mul_mcand << 1;
      r_mul_mplier <= r_mul_mplier >> 1;
      r_mul_cnt    <= r_mul_cnt + CNT_W'(1);
    end
  end
`else
  assign w_mul_issue = 1'b0;
`endif

  // ---------------- issue FSM ----------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_load_out     = 1'b0;
    w_out_result_d = r_out_result;
    w_out_ovf_d    = r_out_overflow;
    w_out_err_d    = r_out_err;
    w_mul_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && w_out_free) begin
          w_pop = 1'b1;
          if (w_mul_issue) begin
            w_mul_start  = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_load_out     = 1'b1;
            w_out_result_d = w_alu_result;
            w_out_ovf_d    = w_alu_ovf;
            w_out_err_d    = w_alu_err;
          end
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        if (w_mul_last) begin
          if (w_out_free) begin
            w_load_out                  = 1'b1;
            w_out_result_d              = w_mul_acc_step[WIDTH-1:0];
            w_out_ovf_d                 = '0;
            w_out_ovf_d[OVF_UNSIGNED]   = |w_mul_acc_step[2*WIDTH-1:WIDTH];
            w_out_err_d                 = 1'b0;
            w_state_next                = ST_IDLE;
          end else begin
            w_state_next = ST_HOLD;
          end
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_HOLD: begin
`ifdef ALU_MUL_EN
        // Finished product parked in r_mul_acc until the output slot frees.
        if (w_out_free) begin
          w_load_out                = 1'b1;
          w_out_result_d            = r_mul_acc[WIDTH-1:0];
          w_out_ovf_d               = '0;
          w_out_ovf_d[OVF_UNSIGNED] = |r_mul_acc[2*WIDTH-1:WIDTH];
          w_out_err_d               = 1'b0;
          w_state_next              = ST_IDLE;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- output register ----------------
  // Payload only changes on a load, and a load needs a free slot, so a
  // stalled result can never be overwritten.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_overflow <= '0;
      r_out_err      <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= w_out_result_d;
      r_out_overflow <= w_out_ovf_d;
      r_out_err      <= w_out_err_d;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_overflow = r_out_overflow;
  assign out_err      = r_out_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage (WIDTH=16, DEPTH=4). Expected values are
// hand-computed constants. Honours ALU_MUL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_overflow;
  logic             out_err;
  alu_state_e       dbg_state;

  always #5 clk = ~clk;

  alu_issue_stage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_opcode    (in_opcode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_err      (out_err),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Back-to-back stream: ADD 1+1, XOR, ADD with carry, SUB to zero.
  logic [WIDTH-1:0] tp_a   [4] = '{16'h0001, 16'h1234, 16'hFFF0, 16'h8000};
  logic [WIDTH-1:0] tp_b   [4] = '{16'h0001, 16'h4321, 16'h0020, 16'h8000};
  logic [2:0]       tp_op  [4] = '{3'b000, 3'b101, 3'b000, 3'b010};
  logic [WIDTH-1:0] tp_exp [4] = '{16'h0002, 16'h5115, 16'h0010, 16'h0000};

  // Backpressure stream: ADD x+0, so each result equals its A operand.
  logic [WIDTH-1:0] bp_a [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  // Offers one command with out_ready=1, measures cycles from the accept
  // cycle (0) to the first cycle out_valid is seen, checks the result.
  task automatic issue(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [15:0] e_res,
                       input logic [1:0] e_ovf, input logic e_err, input int e_lat);
    int lat;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check({tag, "_result"}, 32'(out_result), 32'(e_res));
    check({tag, "_overflow"}, 32'(out_overflow), 32'(e_ovf));
    check({tag, "_err"}, 32'(out_err), 32'(e_err));
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic saw_valid;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_opcode = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_overflow", 32'(out_overflow), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b0;
    tick();

    // Single commands, out_ready held high.
    out_ready = 1'b1;
    issue("add_carry",  16'hFFFF, 16'h0001, 3'b000, 16'h0000, 2'b01, 1'b0, 2);
    issue("add_sovf",   16'h7FFF, 16'h0001, 3'b000, 16'h8000, 2'b10, 1'b0, 2);
    issue("sub_sovf",   16'h8000, 16'h0001, 3'b010, 16'h7FFF, 2'b10, 1'b0, 2);
    issue("sub_borrow", 16'h0001, 16'h0002, 3'b010, 16'hFFFF, 2'b01, 1'b0, 2);
    issue("and",        16'hF0F0, 16'h3C3C, 3'b011, 16'h3030, 2'b00, 1'b0, 2);
    issue("or",         16'hF0F0, 16'h0F01, 3'b100, 16'hFFF1, 2'b00, 1'b0, 2);
    issue("xor",        16'hAAAA, 16'hFFFF, 3'b101, 16'h5555, 2'b00, 1'b0, 2);
    issue("not",        16'h1234, 16'hFFFF, 3'b110, 16'hEDCB, 2'b00, 1'b0, 2);
    issue("illegal",    16'hFFFF, 16'hFFFF, 3'b111, 16'h0000, 2'b00, 1'b1, 2);
`ifdef ALU_MUL_EN
    issue("mul_high",   16'h0100, 16'h0100, 3'b001, 16'h0000, 2'b01, 1'b0, 18);
    issue("mul_small",  16'h0003, 16'h0005, 3'b001, 16'h000F, 2'b00, 1'b0, 18);
`else
    issue("mul_off",    16'h0100, 16'h0100, 3'b001, 16'h0000, 2'b00, 1'b1, 2);
    issue("mul_off2",   16'h0003, 16'h0005, 3'b001, 16'h0000, 2'b00, 1'b1, 2);
`endif

    // Back-to-back stream: one result per cycle once the pipe is primed.
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid  = 1'b1;
        in_a      = tp_a[c];
        in_b      = tp_b[c];
        in_opcode = tp_op[c];
        exp_q.push_back(tp_exp[c]);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2) begin
        check($sformatf("tp_valid_%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("tp_result_%0d", c), 32'(out_result), 32'(exp_q.pop_front()));
      end
      tick();
    end
    check("tp_drained", 32'(out_valid), 32'd0);

    // Backpressure: 4 FIFO entries plus 1 held result, then in_ready drops.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      in_a      = bp_a[k];
      in_b      = 16'h0000;
      in_opcode = 3'b000;
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd1);
      exp_q.push_back(bp_a[k]);
      tick();
    end
    in_a = bp_a[5];
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp_hold_valid_%0d", s), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_result_%0d", s), 32'(out_result), 32'(bp_a[0]));
      check($sformatf("bp_hold_ovf_%0d", s), 32'(out_overflow), 32'd0);
      check($sformatf("bp_hold_in_ready_%0d", s), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_drain_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_drain_result_%0d", k), 32'(out_result), 32'(exp_q.pop_front()));
      tick();
    end
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Reset while a MUL is in flight with two commands queued behind it.
    in_valid  = 1'b1;
    in_a      = 16'h0100;
    in_b      = 16'h0100;
    in_opcode = 3'b001;
    tick();
    in_a      = 16'h0001;
    in_b      = 16'h0001;
    in_opcode = 3'b000;
    tick();
    in_a      = 16'h0002;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
`ifdef ALU_MUL_EN
    check("mid_mul_state", 32'(dbg_state), 32'(ST_MUL));
`endif
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_rst_result", 32'(out_result), 32'd0);
    check("post_rst_err", 32'(out_err), 32'd0);
    saw_valid = 1'b0;
    for (int w = 0; w < 30; w++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("post_rst_no_result", 32'(saw_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter DEPTH, default 4, command FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-high, despite the suffix.
REQ-005 in_valid  input  1  command offered.
REQ-006 in_ready  output  1  command accepted when in_valid && in_ready.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_opcode  input  3  000 ADD, 001 MUL, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT(A), 111 illegal.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 out_result  output  WIDTH  operation result.
REQ-013 out_overflow  output  2  bit0 unsigned carry/borrow/high-half-nonzero; bit1 signed overflow.
REQ-014 out_err  output  1  illegal or compiled-out opcode.

Function
REQ-015 The FIFO SHALL store {a,b,opcode} in order; in_ready = !full; no same-cycle bypass when full.
REQ-016 The FSM SHALL have states IDLE, MUL, HOLD.
REQ-017 IDLE: when the FIFO is non-empty and (!out_valid || out_ready), the block SHALL pop the head; non-MUL ops load the output register on that edge; MUL goes to MUL.
REQ-018 Accept-to-out_valid latency SHALL be 2 cycles minimum for non-MUL ops.
REQ-019 ADD/SUB results SHALL be modulo 2^WIDTH; bit0 = carry-out (ADD) or borrow, a<b unsigned (SUB); bit1 = two's-complement overflow.
REQ-020 AND/OR/XOR/NOT SHALL set out_overflow = 00.
REQ-021 Opcode 111 SHALL produce result 0, overflow 00, out_err = 1, still consuming one output slot.
REQ-022 While out_valid && !out_ready, out_result, out_overflow and out_err SHALL stay stable.
REQ-023 A pop and an output drain in the same cycle SHALL sustain one result per cycle for non-MUL streams.
REQ-024 Push and pop in the same cycle SHALL leave the occupancy count unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 On rst_n = 1 at a clock edge: FIFO empty, FSM IDLE, out_valid = 0, out_result = 0, out_overflow = 00, out_err = 0, in_ready = 1 in the next cycle.
REQ-026 Reset mid-MUL or during HOLD SHALL discard all queued and in-flight commands without emitting a result.

Configuration
REQ-027 With ALU_MUL_EN defined: MUL SHALL use a shift-add multiplier taking WIDTH cycles in state MUL.
REQ-028 With ALU_MUL_EN defined: MUL SHALL then load the low WIDTH bits into out_result; bit0 = 1 iff the high WIDTH bits are nonzero; bit1 = 0.
REQ-029 With ALU_MUL_EN defined: the FSM SHALL enter HOLD if the output register is still occupied; otherwise it SHALL return to IDLE.
REQ-030 Without ALU_MUL_EN, MUL SHALL behave as an illegal opcode (result 0, out_err = 1), the MUL state SHALL be unreachable, and no multiplier logic SHALL be synthesised.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum, the overflow bit indices, and the FSM state typedef.
REQ-032 The FIFO SHALL be sub-module alu_cmd_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-033 ADD 0xFFFF + 0x0001, out_ready = 1 -> result 0x0000, overflow 01, out_valid 2 cycles after accept.
REQ-034 SUB 0x8000 - 0x0001 -> result 0x7FFF, overflow 10; SUB 0x0001 - 0x0002 -> 0xFFFF, overflow 01.
REQ-035 out_ready = 0 with 5 commands offered -> in_ready drops after 4 FIFO entries plus 1 held result; first result stable until out_ready = 1, then in-order delivery.
REQ-036 ALU_MUL_EN defined: MUL 0x0100 * 0x0100 -> result 0x0000, overflow 01, after 16 MUL cycles; without the macro -> result 0, out_err = 1.
REQ-037 Opcode 111 -> out_err = 1, result 0.
REQ-038 rst_n asserted mid-MUL with 2 queued commands -> no out_valid afterwards; in_ready = 1 the cycle after reset.
